// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: bus widths, bus field offsets,
// one-hot ALU operation indices and the multiplier state encoding.
package exe_pkg;

    localparam int ID_EXE_W  = 156;
    localparam int EXE_MEM_W = 106;
    localparam int MEM_WB_W  = 70;

    // ID->EXE bus field positions (single bits and LSBs of multi-bit fields)
    localparam int ID_MULTIPLY    = 155;
    localparam int ID_MULT_SIGNED = 154;
    localparam int ID_MTHI        = 153;
    localparam int ID_MTLO        = 152;
    localparam int ID_MFHI        = 151;
    localparam int ID_MFLO        = 150;
    localparam int ID_ALU_CTL_LSB = 138;
    localparam int ID_OP1_LSB     = 106;
    localparam int ID_OP2_LSB     = 74;
    localparam int ID_MEM_CTL_LSB = 70;
    localparam int ID_STORE_LSB   = 38;
    localparam int ID_RF_WEN      = 37;
    localparam int ID_WDEST_LSB   = 32;
    localparam int ID_PC_LSB      = 0;

    // EXE->MEM bus field positions
    localparam int EM_MEM_CTL_LSB = 102;
    localparam int EM_STORE_LSB   = 70;
    localparam int EM_RESULT_LSB  = 38;
    localparam int EM_RF_WEN      = 37;
    localparam int EM_WDEST_LSB   = 32;
    localparam int EM_PC_LSB      = 0;

    // One-hot ALU control bit indices
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/exe_multiplier.sv
// Iterative shift-add multiplier: magnitudes are multiplied over STEPS cycles,
// the sign is applied to the final product, and done pulses for one cycle.
module exe_multiplier
    import exe_pkg::*;
#(
    parameter int STEPS = 32
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        is_signed,
    output logic        done,
    output logic [63:0] product
);

    mul_state_t  state;
    logic [4:0]  count;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic        negate;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MUL_IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            negate <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {32'd0, is_signed ? abs32(op1) : op1};
                        mplier <= is_signed ? abs32(op2) : op2;
                        negate <= is_signed & (op1[31] ^ op2[31]);
                        acc    <= '0;
                        count  <= '0;
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    // mcand is pre-shifted each step, so it always equals multiplicand<<count
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                    if (count == 5'(STEPS - 1)) begin
                        state <= MUL_DONE;
                        done  <= 1'b1;
                    end
                end
                MUL_DONE: begin
                    done  <= 1'b0;
                    state <= MUL_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= MUL_IDLE;
                end
            endcase
        end
    end

    assign product = negate ? (64'd0 - acc) : acc;

endmodule

// File: rtl/st3_exe.sv
// Execute stage: single-cycle one-hot ALU, HI/LO registers with move
// instructions, and an iterative multiplier that writes HI/LO on completion.
module st3_exe
    import exe_pkg::*;
#(
    parameter int MUL_STEPS = 32   // only 32 is supported
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EXE_valid,
    input  logic [ID_EXE_W-1:0]  ID_EXE_bus_r,
    output logic                 EXE_over,
    output logic [EXE_MEM_W-1:0] EXE_MEM_bus,
    output logic [31:0]          EXE_pc
);

    logic        multiply, mult_signed, mthi, mtlo, mfhi, mflo;
    logic [11:0] alu_ctl;
    logic [31:0] op1, op2, store_data, pc;
    logic [3:0]  mem_control;
    logic        rf_wen;
    logic [4:0]  rf_wdest;

    assign multiply    = ID_EXE_bus_r[ID_MULTIPLY];
    assign mult_signed = ID_EXE_bus_r[ID_MULT_SIGNED];
    assign mthi        = ID_EXE_bus_r[ID_MTHI];
    assign mtlo        = ID_EXE_bus_r[ID_MTLO];
    assign mfhi        = ID_EXE_bus_r[ID_MFHI];
    assign mflo        = ID_EXE_bus_r[ID_MFLO];
    assign alu_ctl     = ID_EXE_bus_r[ID_ALU_CTL_LSB +: 12];
    assign op1         = ID_EXE_bus_r[ID_OP1_LSB +: 32];
    assign op2         = ID_EXE_bus_r[ID_OP2_LSB +: 32];
    assign mem_control = ID_EXE_bus_r[ID_MEM_CTL_LSB +: 4];
    assign store_data  = ID_EXE_bus_r[ID_STORE_LSB +: 32];
    assign rf_wen      = ID_EXE_bus_r[ID_RF_WEN];
    assign rf_wdest    = ID_EXE_bus_r[ID_WDEST_LSB +: 5];
    assign pc          = ID_EXE_bus_r[ID_PC_LSB +: 32];

    logic [31:0] alu_out;

    // NOTE: alu_out gets a default before the decode so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_out = '0;
        if      (alu_ctl[ALU_ADD])  alu_out = op1 + op2;
        else if (alu_ctl[ALU_SUB])  alu_out = op1 - op2;
        else if (alu_ctl[ALU_SLT])  alu_out = {31'd0, $signed(op1) < $signed(op2)};
        else if (alu_ctl[ALU_SLTU]) alu_out = {31'd0, op1 < op2};
        else if (alu_ctl[ALU_AND])  alu_out = op1 & op2;
        else if (alu_ctl[ALU_NOR])  alu_out = ~(op1 | op2);
        else if (alu_ctl[ALU_OR])   alu_out = op1 | op2;
        else if (alu_ctl[ALU_XOR])  alu_out = op1 ^ op2;
        else if (alu_ctl[ALU_SLL])  alu_out = op2 << op1[4:0];
        else if (alu_ctl[ALU_SRL])  alu_out = op2 >> op1[4:0];
        else if (alu_ctl[ALU_SRA])  alu_out = $unsigned($signed(op2) >>> op1[4:0]);
        else if (alu_ctl[ALU_LUI])  alu_out = {op2[15:0], 16'd0};
    end

    logic        mul_done;
    logic [63:0] mul_product;

    exe_multiplier #(.STEPS(MUL_STEPS)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (EXE_valid & multiply),
        .op1       (op1),
        .op2       (op2),
        .is_signed (mult_signed),
        .done      (mul_done),
        .product   (mul_product)
    );

    logic [31:0] hi, lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_done) begin
            {hi, lo} <= mul_product;
        end else if (EXE_valid) begin
            if (mthi) hi <= op1;
            if (mtlo) lo <= op1;
        end
    end

    logic [31:0] alu_result;
    assign alu_result = mfhi ? hi : (mflo ? lo : alu_out);

    // Non-multiply instructions complete in their issue cycle; multiplies on done
    assign EXE_over    = mul_done | (EXE_valid & ~multiply);
    assign EXE_MEM_bus = {mem_control, store_data, alu_result, rf_wen, rf_wdest, pc};
    assign EXE_pc      = pc;

endmodule

// File: tb/tb_st3_exe.sv
// Self-checking bench for st3_exe: a cycle-level reference model compared every
// cycle, plus directed vectors with hand-computed expected values.
module tb_st3_exe;

    logic         clk;
    logic         rst;
    logic         EXE_valid;
    logic [155:0] ID_EXE_bus_r;
    logic         EXE_over;
    logic [105:0] EXE_MEM_bus;
    logic [31:0]  EXE_pc;

    st3_exe dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_valid    (EXE_valid),
        .ID_EXE_bus_r (ID_EXE_bus_r),
        .EXE_over     (EXE_over),
        .EXE_MEM_bus  (EXE_MEM_bus),
        .EXE_pc       (EXE_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [11:0] C_ADD  = 12'h800;
    localparam logic [11:0] C_SUB  = 12'h400;
    localparam logic [11:0] C_SLT  = 12'h200;
    localparam logic [11:0] C_SLTU = 12'h100;
    localparam logic [11:0] C_AND  = 12'h080;
    localparam logic [11:0] C_NOR  = 12'h040;
    localparam logic [11:0] C_OR   = 12'h020;
    localparam logic [11:0] C_XOR  = 12'h010;
    localparam logic [11:0] C_SLL  = 12'h008;
    localparam logic [11:0] C_SRL  = 12'h004;
    localparam logic [11:0] C_SRA  = 12'h002;
    localparam logic [11:0] C_LUI  = 12'h001;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [155:0] mk(input logic mul, input logic sgn,
                                        input logic hi_w, input logic lo_w,
                                        input logic hi_r, input logic lo_r,
                                        input logic [11:0] ctl,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] pc);
        logic [4:0] dest;
        dest = pc[4:0] | 5'd1;
        return {mul, sgn, hi_w, lo_w, hi_r, lo_r, ctl, a, b, 4'hA, a ^ b, ~mul, dest, pc};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [11:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sb;
        sb = b;
        case (ctl)
            C_ADD:   return a + b;
            C_SUB:   return a - b;
            C_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            C_AND:   return a & b;
            C_NOR:   return ~(a | b);
            C_OR:    return a | b;
            C_XOR:   return a ^ b;
            C_SLL:   return b << a[4:0];
            C_SRL:   return b >> a[4:0];
            C_SRA:   return sb >>> a[4:0];
            C_LUI:   return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: architectural HI/LO plus one outstanding multiply that
    // completes a fixed 33 cycles after its issue cycle.
    int          cyc = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_busy = 1'b0;
    int          m_start = 0;
    logic [63:0] m_prod = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_hi   = '0;
            m_lo   = '0;
            m_busy = 1'b0;
        end else if (m_busy && cyc == m_start + 33) begin
            m_hi   = m_prod[63:32];
            m_lo   = m_prod[31:0];
            m_busy = 1'b0;
        end else if (!m_busy && EXE_valid) begin
            if (ID_EXE_bus_r[155]) begin
                m_busy  = 1'b1;
                m_start = cyc;
                if (ID_EXE_bus_r[154])
                    m_prod = $signed({{32{ID_EXE_bus_r[137]}}, ID_EXE_bus_r[137:106]}) *
                             $signed({{32{ID_EXE_bus_r[105]}}, ID_EXE_bus_r[105:74]});
                else
                    m_prod = {32'd0, ID_EXE_bus_r[137:106]} * {32'd0, ID_EXE_bus_r[105:74]};
            end
            if (ID_EXE_bus_r[153]) m_hi = ID_EXE_bus_r[137:106];
            if (ID_EXE_bus_r[152]) m_lo = ID_EXE_bus_r[137:106];
        end
        cyc++;
    end

    logic        exp_over;
    logic [31:0] exp_res;

    always @(negedge clk) begin
        exp_over = m_busy ? (cyc == m_start + 33) : (EXE_valid && !ID_EXE_bus_r[155]);
        check("model_over", EXE_over, exp_over);
        if (exp_over) begin
            exp_res = ID_EXE_bus_r[151] ? m_hi :
                      ID_EXE_bus_r[150] ? m_lo :
                      ref_alu(ID_EXE_bus_r[149:138], ID_EXE_bus_r[137:106], ID_EXE_bus_r[105:74]);
            check("model_bus", EXE_MEM_bus,
                  {ID_EXE_bus_r[73:70], ID_EXE_bus_r[69:38], exp_res, ID_EXE_bus_r[37:32],
                   ID_EXE_bus_r[31:0]});
            check("model_pc", EXE_pc, ID_EXE_bus_r[31:0]);
        end
    end

    // One-cycle issue of a non-multiply instruction; samples in the issue cycle.
    task automatic pulse(input logic [155:0] b, output logic over_s, output logic [31:0] res_s);
        @(posedge clk);
        #1;
        ID_EXE_bus_r = b;
        EXE_valid    = 1'b1;
        @(negedge clk);
        over_s = EXE_over;
        res_s  = EXE_MEM_bus[69:38];
        @(posedge clk);
        #1;
        EXE_valid = 1'b0;
    endtask

    // Issue a multiply and watch a fixed 40-cycle window for EXE_over pulses.
    task automatic mul_run(input logic [155:0] b, input int inject_at, input int rst_at,
                           output int lat, output int cnt);
        lat = 0;
        cnt = 0;
        @(posedge clk);
        #1;
        ID_EXE_bus_r = b;
        EXE_valid    = 1'b1;
        @(negedge clk);
        check("mul_over_issue", EXE_over, 1'b0);
        @(posedge clk);
        #1;
        for (int n = 1; n <= 40; n++) begin
            EXE_valid = (n == inject_at);
            rst       = (n == rst_at);
            @(negedge clk);
            if (EXE_over) begin
                cnt++;
                lat = n;
            end
            @(posedge clk);
            #1;
        end
        EXE_valid = 1'b0;
        rst       = 1'b0;
    endtask

    logic        o;
    logic [31:0] r;
    int          lat, cnt;

    initial begin
        rst          = 1'b1;
        EXE_valid    = 1'b0;
        ID_EXE_bus_r = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        pulse(mk(0, 0, 0, 0, 1, 0, 12'h0, 32'd0, 32'd0, 32'h100), o, r);
        check("reset_hi", r, 32'd0);
        pulse(mk(0, 0, 0, 0, 0, 1, 12'h0, 32'd0, 32'd0, 32'h104), o, r);
        check("reset_lo", r, 32'd0);

        pulse(mk(0, 0, 0, 0, 0, 0, C_ADD, 32'd5, 32'd7, 32'h108), o, r);
        check("add_over", o, 1'b1);
        check("add_res", r, 32'd12);
        check("add_store", EXE_MEM_bus[101:70], 32'd2);
        check("add_pc", EXE_pc, 32'h108);

        pulse(mk(0, 0, 0, 0, 0, 0, C_SLT, 32'hFFFF_FFFF, 32'd1, 32'h10C), o, r);
        check("slt_res", r, 32'd1);
        pulse(mk(0, 0, 0, 0, 0, 0, C_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h110), o, r);
        check("sltu_res", r, 32'd0);
        pulse(mk(0, 0, 0, 0, 0, 0, C_SRA, 32'd4, 32'h8000_0000, 32'h114), o, r);
        check("sra_res", r, 32'hF800_0000);
        pulse(mk(0, 0, 0, 0, 0, 0, C_LUI, 32'd0, 32'h0000_1234, 32'h118), o, r);
        check("lui_res", r, 32'h1234_0000);
        pulse(mk(0, 0, 0, 0, 0, 0, C_SUB, 32'd3, 32'd5, 32'h11C), o, r);
        check("sub_res", r, 32'hFFFF_FFFE);
        pulse(mk(0, 0, 0, 0, 0, 0, C_SRL, 32'd4, 32'h8000_0000, 32'h120), o, r);
        check("srl_res", r, 32'h0800_0000);
        pulse(mk(0, 0, 0, 0, 0, 0, C_NOR, 32'h0F0F_0000, 32'h0000_00FF, 32'h124), o, r);
        check("nor_res", r, 32'hF0F0_FF00);
        pulse(mk(0, 0, 0, 0, 0, 0, C_SLL, 32'd35, 32'd1, 32'h128), o, r);
        check("sll_res", r, 32'd8);
        pulse(mk(0, 0, 0, 0, 0, 0, C_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h12C), o, r);
        pulse(mk(0, 0, 0, 0, 0, 0, C_OR,  32'hFF00_0000, 32'h0000_00FF, 32'h130), o, r);
        pulse(mk(0, 0, 0, 0, 0, 0, C_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h134), o, r);
        check("xor_res", r, 32'h5555_5555);
        pulse(mk(0, 0, 0, 0, 0, 0, 12'h0, 32'd5, 32'd7, 32'h138), o, r);
        check("zero_ctl_res", r, 32'd0);

        mul_run(mk(1, 0, 0, 0, 0, 0, 12'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h200), 0, 0, lat, cnt);
        check("multu_lat", lat, 33);
        check("multu_cnt", cnt, 1);
        pulse(mk(0, 0, 0, 0, 1, 0, 12'h0, 32'd0, 32'd0, 32'h204), o, r);
        check("multu_hi", r, 32'hFFFF_FFFE);
        pulse(mk(0, 0, 0, 0, 0, 1, 12'h0, 32'd0, 32'd0, 32'h208), o, r);
        check("multu_lo", r, 32'h0000_0001);

        mul_run(mk(1, 1, 0, 0, 0, 0, 12'h0, 32'hFFFF_FFFD, 32'd5, 32'h300), 10, 0, lat, cnt);
        check("mult_lat", lat, 33);
        check("mult_cnt", cnt, 1);
        pulse(mk(0, 0, 0, 0, 1, 0, 12'h0, 32'd0, 32'd0, 32'h304), o, r);
        check("mult_hi", r, 32'hFFFF_FFFF);
        pulse(mk(0, 0, 0, 0, 0, 1, 12'h0, 32'd0, 32'd0, 32'h308), o, r);
        check("mult_lo", r, 32'hFFFF_FFF1);

        pulse(mk(0, 0, 1, 0, 0, 0, 12'h0, 32'hDEAD_BEEF, 32'd0, 32'h400), o, r);
        check("mthi_over", o, 1'b1);
        pulse(mk(0, 0, 0, 0, 1, 0, 12'h0, 32'd0, 32'd0, 32'h404), o, r);
        check("mthi_mfhi", r, 32'hDEAD_BEEF);
        pulse(mk(0, 0, 0, 1, 0, 0, 12'h0, 32'd1, 32'd0, 32'h408), o, r);
        check("mtlo_over", o, 1'b1);
        pulse(mk(0, 0, 0, 0, 0, 1, 12'h0, 32'd0, 32'd0, 32'h40C), o, r);
        check("mtlo_mflo", r, 32'd1);

        mul_run(mk(1, 0, 0, 0, 0, 0, 12'h0, 32'h1234_5678, 32'd9, 32'h500), 0, 15, lat, cnt);
        check("rst_mul_cnt", cnt, 0);
        pulse(mk(0, 0, 0, 0, 1, 0, 12'h0, 32'd0, 32'd0, 32'h504), o, r);
        check("rst_mul_hi", r, 32'd0);
        pulse(mk(0, 0, 0, 0, 0, 1, 12'h0, 32'd0, 32'd0, 32'h508), o, r);
        check("rst_mul_lo", r, 32'd0);
        pulse(mk(0, 0, 0, 0, 0, 0, C_ADD, 32'd100, 32'd23, 32'h50C), o, r);
        check("post_rst_add_over", o, 1'b1);
        check("post_rst_add_res", r, 32'd123);

        mul_run(mk(1, 1, 0, 0, 0, 0, 12'h0, 32'd7, 32'hFFFF_FFFE, 32'h600), 0, 0, lat, cnt);
        check("post_rst_mult_lat", lat, 33);
        pulse(mk(0, 0, 0, 0, 0, 1, 12'h0, 32'd0, 32'd0, 32'h604), o, r);
        check("post_rst_mult_lo", r, 32'hFFFF_FFF2);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/st3_exe.md
Name: st3_exe

Overview:
- Execute stage of the multi-cycle CPU, sitting between decode and the memory-access stage (st4_mem).
- Consumes the registered ID->EXE bus and performs one-hot ALU operations, single-cycle.
- Runs an iterative 32-step shift-add multiplier (MULT/MULTU) that writes the HI/LO registers; also executes MFHI/MFLO/MTHI/MTLO.
- Produces the 106-bit EXE->MEM bus and the EXE_over completion pulse.

Parameters:
- MUL_STEPS, 32, number of multiplier iterations; only 32 is supported.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous active-high reset.
- EXE_valid  in  1  one-cycle start pulse; ID_EXE_bus_r is stable from this cycle until the next pulse.
- ID_EXE_bus_r  in  156  {multiply, mult_signed, mthi, mtlo, mfhi, mflo, alu_control[11:0], alu_operand1[31:0], alu_operand2[31:0], mem_control[3:0], store_data[31:0], rf_wen, rf_wdest[4:0], pc[31:0]}, MSB first.
- EXE_over  out  1  execute complete; one-cycle pulse.
- EXE_MEM_bus  out  106  {mem_control[3:0], store_data[31:0], alu_result[31:0], rf_wen, rf_wdest[4:0], pc[31:0]}.
- EXE_pc  out  32  pc, for display.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: FSM=IDLE, HI=0, LO=0, EXE_over=0, multiplier datapath=0.
- EXE_MEM_bus fields mem_control, store_data, rf_wen, rf_wdest and pc pass through combinationally from ID_EXE_bus_r. EXE_pc = pc.
- alu_control is one-hot, bit11..bit0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Arithmetic is modulo 2^32 with no overflow trap.
  - slt is signed and sltu is unsigned; both give a 0/1 result.
  - Shifts move alu_operand2 by alu_operand1[4:0].
  - lui = {alu_operand2[15:0],16'h0}.
  - All-zero alu_control gives result 0.
  - Multiple bits set is undefined; the bench must not drive it.
- alu_result priority: mfhi -> HI; mflo -> LO; otherwise the ALU output.
- Non-multiply instruction: EXE_over = EXE_valid, combinationally in the same cycle, with zero latency.
- mthi/mtlo: HI (or LO) <= alu_operand1 on the clk edge where EXE_valid=1.
- Multiplier FSM (IDLE, BUSY, DONE):
  - IDLE -> BUSY on EXE_valid && multiply. Latch |op1| and |op2| when mult_signed=1, raw values otherwise. Latch the result sign = op1[31]^op2[31] (signed only). Clear the 64-bit product and set the step counter to 0.
  - BUSY: each cycle, if multiplier LSB=1 then product += multiplicand<<step. The multiplier shifts right and the counter increments. After step 31 -> DONE.
  - DONE: EXE_over=1 for exactly one cycle (registered output). At the end of DONE, {HI,LO} <= sign ? -product : product. Then -> IDLE.
  - Latency: EXE_valid in cycle 0 gives EXE_over in cycle 33.
- EXE_valid while in BUSY/DONE is ignored: no restart and no extra EXE_over.
- MFHI/MFLO issued after a multiply read the updated HI/LO, because the next EXE_valid can only follow EXE_over.
- Reset during BUSY/DONE: returns to IDLE next edge, HI/LO are zeroed, no EXE_over, partial product discarded.
- Multiply instructions carry rf_wen=0, set by the decoder; this block does not force it.

Decomposition:
- Shared package exe_pkg holds:
  - bus widths (ID_EXE_W=156, EXE_MEM_W=106, MEM_WB_W=70);
  - bit-field offsets of both buses;
  - one-hot ALU index constants ALU_ADD..ALU_LUI;
  - FSM state encoding.
- One sub-module, exe_multiplier, owns the FSM, counter, operands, product and sign fix-up. Its interface is start/op1/op2/is_signed -> done/product[63:0]. The ALU and HI/LO registers stay in st3_exe.

Test Plan:
- add: op1=5, op2=7, one-hot add, EXE_valid pulse -> same cycle EXE_over=1, alu_result=12, other bus fields equal the inputs.
- slt/sltu with op1=0xFFFFFFFF, op2=1 -> slt result 1, sltu result 0. sra with op1=4, op2=0x80000000 -> 0xF8000000. lui with op2=0x1234 -> 0x12340000.
- multu 0xFFFFFFFF x 0xFFFFFFFF, valid at cycle 0 -> EXE_over only at cycle 33. Following mfhi -> 0xFFFFFFFE, mflo -> 0x00000001.
- mult signed -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Second EXE_valid pulse at cycle 10 is ignored, with a single EXE_over at cycle 33.
- mthi 0xDEADBEEF then mfhi -> 0xDEADBEEF; mtlo 0x1 then mflo -> 0x1. Each EXE_over is in the same cycle as its valid.
- rst asserted in cycle 15 of a multu -> no EXE_over, FSM in IDLE, mfhi/mflo return 0. A new add completes normally.
